fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the 16-bit pipelined processor. It sits directly upstream of the decode stage. Each cycle it reads one 16-bit halfword from a synchronous instruction memory and assembles two consecutive halfwords into the 32-bit instruction word consumed by decode, where the opcode is instr[31:27]. It also maintains the PC, takes redirects from later stages, and holds its output while decode stalls.

## Interface
Parameters:
- ADDR_W, 16, width of PC and instruction-memory address (halfword addressed)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  decode cannot accept; output register must hold
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- imem_en  out  1  read strobe (combinational)
- imem_addr  out  ADDR_W  read address (combinational)
- imem_rdata  in  16  data for the address strobed on the previous cycle (fixed 1-cycle latency)
- instr  out  32  assembled instruction; [31:16]=mem[pc], [15:0]=mem[pc+1]
- instr_pc  out  ADDR_W  address of instr's first halfword
- instr_valid  out  1  instr is meaningful; decode ignores instr when 0
- pc  out  ADDR_W  fetch_pc, the address of the instruction currently being assembled

## Operation
- Registers: fetch_pc, state, hi_reg (16), pend_instr (32), pend_pc, and output regs instr / instr_pc / instr_valid.
- slot_free = !instr_valid || !stall. Decode consumes on any cycle with instr_valid && !stall.
- States:
  - S_START: imem_en=1, addr=fetch_pc. Next state S_LO.
  - S_LO: hi_reg<=imem_rdata. imem_en=1, addr=fetch_pc+1. Next state S_HI.
  - S_HI: the assembled word is {hi_reg, imem_rdata}, and fetch_pc<=fetch_pc+2.
    - If slot_free: load the output regs with the word and instr_pc=old fetch_pc, set instr_valid=1, imem_en=1, addr=new fetch_pc (fetch_pc+2). Next state S_LO.
    - Else: pend_instr/pend_pc<=the word and old fetch_pc, imem_en=0. Next state S_WAIT.
  - S_WAIT: imem_en=0 while stall=1.
    - When stall=0: load the output from pend_*, imem_en=1, addr=fetch_pc. Next state S_LO.
- On any cycle where the output is not loaded and slot_free, instr_valid<=0 (consumed).
- Priority order: reset > redirect > normal operation.
- Redirect:
  - fetch_pc<=redirect_pc, state<=S_START, instr_valid<=0, pending discarded.
  - imem_en=0 in the redirect cycle.
  - Data returning the cycle after a redirect is ignored.
- Reset:
  - fetch_pc=RESET_PC, state=S_START, instr=0, instr_pc=0, instr_valid=0, hi_reg/pend=0.
  - imem_en=0 while reset=1.
- Address arithmetic is modulo 2^ADDR_W. fetch_pc+1 and fetch_pc+2 wrap with no error.
- Stall while instr_valid=0 has no effect; slot_free=1.

## Timing
- Reset released at cycle 0:
  - Cycle 0: S_START read of RESET_PC.
  - Cycle 1: read of RESET_PC+1.
  - Cycle 2: assemble.
  - Cycle 3: instr_valid=1.
- Steady state without stall: one instruction per 2 cycles. instr_valid is high on alternate cycles.
- Redirect at cycle r:
  - imem_addr=redirect_pc at r+1.
  - The first valid instr has instr_pc=redirect_pc at r+4.
- Stall release at cycle t with a pending word: the pending word is visible at t+1, and the next hi read is issued at t.
- Outputs change only on clock edges; imem_en and imem_addr are combinational from state/fetch_pc/stall/redirect/reset.

## Test plan
- Reset, RESET_PC=0, mem[0..3]=0x0800,0x1234,0x1000,0xABCD -> instr=0x08001234, instr_pc=0 valid at cycle 3; instr=0x1000ABCD, instr_pc=2 valid at cycle 5.
- stall=1 from cycle 3 to cycle 8 -> instr holds 0x08001234. At cycle 5, pend captures instr_pc=2 and imem_en stays 0 while stalled. On release, instr_pc=2 appears the next cycle, then instr_pc=4 two cycles later, with no skipped or duplicated PC.
- redirect=1, redirect_pc=0x0040 during S_LO -> instr_valid=0 next cycle, imem_addr=0x0040 next cycle, valid instr_pc=0x0040 four cycles after the redirect.
- redirect during S_WAIT with stall=1 -> pending word discarded, instr_valid=0, first valid instr_pc=redirect_pc.
- RESET_PC=0xFFFF -> reads at 0xFFFF then 0x0000; instr_pc=0xFFFF, next instr_pc=0x0001.
- reset asserted in S_WAIT -> next cycle instr=0, instr_pc=0, instr_valid=0, pc=RESET_PC, imem_en=0 during reset.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: reads two halfwords per instruction from a 1-cycle-latency
// instruction memory, assembles the 32-bit word, tracks the PC and honours stall/redirect.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_START | issue read of fetch_pc (first cycle after reset/redirect)
// S_LO    | capture high halfword, issue read of fetch_pc+1
// S_HI    | assemble word; hand to output or park in pend if decode stalls
// S_WAIT  | hold parked word until decode frees the output slot
module fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_LO    = 2'd1,
        S_HI    = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_plus1, pc_plus2;
    logic [15:0]       hi_reg;
    logic [31:0]       pend_instr;
    logic [ADDR_W-1:0] pend_pc;
    logic [31:0]       word;
    logic              slot_free;
    logic              load_out;
    logic              load_pend;
    logic              out_from_pend;

    assign pc_plus1  = fetch_pc + ADDR_W'(1);
    assign pc_plus2  = fetch_pc + ADDR_W'(2);
    assign word      = {hi_reg, imem_rdata};
    assign slot_free = !instr_valid || !stall;
    assign pc        = fetch_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_START;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        imem_en       = 1'b0;
        imem_addr     = fetch_pc;
        load_out      = 1'b0;
        load_pend     = 1'b0;
        out_from_pend = 1'b0;
        case (state)
            S_START: begin
                imem_en    = 1'b1;
                state_next = S_LO;
            end
            S_LO: begin
                imem_en    = 1'b1;
                imem_addr  = pc_plus1;
                state_next = S_HI;
            end
            S_HI: begin
                if (slot_free) begin
                    load_out   = 1'b1;
                    imem_en    = 1'b1;
                    imem_addr  = pc_plus2;
                    state_next = S_LO;
                end else begin
                    load_pend  = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // fetch_pc already advanced in S_HI, so it is the next hi address
                if (!stall) begin
                    load_out      = 1'b1;
                    out_from_pend = 1'b1;
                    imem_en       = 1'b1;
                    state_next    = S_LO;
                end
            end
            default: state_next = S_START;
        endcase
        if (reset || redirect) begin
            imem_en   = 1'b0;
            load_out  = 1'b0;
            load_pend = 1'b0;
        end
        if (redirect) begin
            state_next = S_START;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            hi_reg      <= '0;
            pend_instr  <= '0;
            pend_pc     <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            pend_instr  <= '0;
            pend_pc     <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (state == S_LO) begin
                hi_reg <= imem_rdata;
            end
            if (state == S_HI) begin
                fetch_pc <= pc_plus2;
            end
            if (load_pend) begin
                pend_instr <= word;
                pend_pc    <= fetch_pc;
            end
            if (load_out) begin
                instr       <= out_from_pend ? pend_instr : word;
                instr_pc    <= out_from_pend ? pend_pc : fetch_pc;
                instr_valid <= 1'b1;
            end else if (slot_free) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed timing checks plus a randomized stall/redirect run,
// with consumed instructions checked against an expected-stream scoreboard.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, redirect;
    logic [15:0] redirect_pc;
    logic        imem_en;
    logic [15:0] imem_addr, imem_rdata;
    logic [31:0] instr;
    logic [15:0] instr_pc, pc;
    logic        instr_valid;

    logic        stall_w, redirect_w;
    logic [15:0] redirect_pc_w;
    logic        imem_en_w;
    logic [15:0] imem_addr_w, imem_rdata_w;
    logic [31:0] instr_w;
    logic [15:0] instr_pc_w, pc_w;
    logic        instr_valid_w;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          consumed = 0;
    logic [15:0] seed;
    logic [47:0] exp_q[$];
    logic [47:0] exp_q_w[$];
    logic [15:0] next_pc, next_pc_w;

    fetch_stage #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .pc(pc)
    );

    fetch_stage #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u_dut_wrap (
        .clk(clk), .reset(reset), .stall(stall_w), .redirect(redirect_w),
        .redirect_pc(redirect_pc_w), .imem_en(imem_en_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .instr(instr_w), .instr_pc(instr_pc_w),
        .instr_valid(instr_valid_w), .pc(pc_w)
    );

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        logic [15:0] h;
        case (a)
            16'h0000: h = 16'h0800;
            16'h0001: h = 16'h1234;
            16'h0002: h = 16'h1000;
            16'h0003: h = 16'hABCD;
            default: begin
                h = a * 16'h9E37;
                h = h ^ {a[7:0], a[15:8]} ^ seed;
            end
        endcase
        return h;
    endfunction

    function automatic logic [31:0] word_at(input logic [15:0] a);
        logic [15:0] b;
        b = a + 16'd1;
        return {mem_val(a), mem_val(b)};
    endfunction

    // synchronous instruction memories with one-cycle read latency
    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= mem_val(imem_addr);
        if (imem_en_w) imem_rdata_w <= mem_val(imem_addr_w);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // expected stream: consecutive instruction addresses 2 apart from the restart point
    task automatic restart_main(input logic [15:0] start);
        exp_q.delete();
        next_pc = start;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({next_pc, word_at(next_pc)});
            next_pc = next_pc + 16'd2;
        end
    endtask

    task automatic restart_wrap(input logic [15:0] start);
        exp_q_w.delete();
        next_pc_w = start;
        for (int i = 0; i < 4; i++) begin
            exp_q_w.push_back({next_pc_w, word_at(next_pc_w)});
            next_pc_w = next_pc_w + 16'd2;
        end
    endtask

    always @(negedge clk) begin
        logic [47:0] e;
        if (!reset && !redirect && instr_valid && !stall) begin
            while (exp_q.size() < 4) begin
                exp_q.push_back({next_pc, word_at(next_pc)});
                next_pc = next_pc + 16'd2;
            end
            e = exp_q.pop_front();
            chk("stream", 64'({instr_pc, instr}), 64'(e));
            consumed++;
        end
        if (!reset && instr_valid_w) begin
            while (exp_q_w.size() < 4) begin
                exp_q_w.push_back({next_pc_w, word_at(next_pc_w)});
                next_pc_w = next_pc_w + 16'd2;
            end
            e = exp_q_w.pop_front();
            chk("stream_wrap", 64'({instr_pc_w, instr_w}), 64'(e));
        end
    end

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic ne();
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [15:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        restart_main(target);
    endtask

    // leaves the bench just after the edge that starts cycle 0 (reset released)
    task automatic do_reset();
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        nc();
        nc();
        ne();
        chk("rst_imem_en", 64'(imem_en), 64'(0));
        chk("rst_state", 64'({instr_valid, instr_pc, instr, pc}), 64'(0));
        chk("rst_wrap_pc", 64'(pc_w), 64'(16'hFFFF));
        nc();
        reset = 1'b0;
        restart_main(16'h0000);
        restart_wrap(16'hFFFF);
    endtask

    initial begin
        int base;
        logic [15:0] tgt;
        seed          = 16'($urandom);
        reset         = 1'b1;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        stall_w       = 1'b0;
        redirect_w    = 1'b0;
        redirect_pc_w = '0;

        // straight-line fetch from reset, with the wrapping instance alongside
        do_reset();
        ne();
        chk("c0_read", 64'({imem_en, imem_addr}), 64'({1'b1, 16'h0000}));
        chk("c0_wrap_read", 64'({imem_en_w, imem_addr_w}), 64'({1'b1, 16'hFFFF}));
        nc(); ne();
        chk("c1_read", 64'({imem_en, imem_addr}), 64'({1'b1, 16'h0001}));
        chk("c1_wrap_read", 64'(imem_addr_w), 64'(16'h0000));
        nc(); ne();
        chk("c2_valid", 64'(instr_valid), 64'(0));
        nc(); ne();
        chk("c3_out", 64'({instr_valid, instr_pc, instr}), 64'({1'b1, 16'h0000, 32'h08001234}));
        chk("c3_wrap_out", 64'({instr_valid_w, instr_pc_w, instr_w}),
            64'({1'b1, 16'hFFFF, word_at(16'hFFFF)}));
        nc(); ne();
        chk("c4_valid", 64'(instr_valid), 64'(0));
        nc(); ne();
        chk("c5_out", 64'({instr_valid, instr_pc, instr}), 64'({1'b1, 16'h0002, 32'h1000ABCD}));
        chk("c5_wrap_out", 64'({instr_pc_w, instr_w}), 64'({16'h0001, 32'h12341000}));

        // decode stall from cycle 3 to 8
        do_reset();
        nc(); nc(); nc();
        stall = 1'b1;
        ne();
        chk("st_c3_out", 64'({instr_valid, instr}), 64'({1'b1, 32'h08001234}));
        nc(); nc(); ne();
        chk("st_c5_hold", 64'({instr_valid, instr_pc, instr, imem_en}),
            64'({1'b1, 16'h0000, 32'h08001234, 1'b0}));
        for (int c = 6; c <= 8; c++) begin
            nc(); ne();
            chk("st_en_low", 64'(imem_en), 64'(0));
        end
        nc();
        stall = 1'b0;
        ne();
        chk("st_release_read", 64'({imem_en, imem_addr}), 64'({1'b1, 16'h0004}));
        nc(); ne();
        chk("st_pend_out", 64'({instr_valid, instr_pc, instr}), 64'({1'b1, 16'h0002, 32'h1000ABCD}));
        nc(); ne();
        chk("st_gap", 64'(instr_valid), 64'(0));
        nc(); ne();
        chk("st_next_out", 64'({instr_valid, instr_pc, instr}), 64'({1'b1, 16'h0004, word_at(16'h0004)}));

        // redirect while assembling (S_LO)
        do_reset();
        nc(); nc(); nc();
        do_redirect(16'h0040);
        ne();
        chk("rd_en_low", 64'(imem_en), 64'(0));
        nc();
        redirect = 1'b0;
        ne();
        chk("rd_next", 64'({instr_valid, imem_en, imem_addr}), 64'({1'b0, 1'b1, 16'h0040}));
        nc(); nc(); ne();
        chk("rd_r3_valid", 64'(instr_valid), 64'(0));
        nc(); ne();
        chk("rd_r4_out", 64'({instr_valid, instr_pc, instr}), 64'({1'b1, 16'h0040, word_at(16'h0040)}));

        // redirect while parked in S_WAIT
        do_reset();
        nc(); nc(); nc();
        stall = 1'b1;
        nc(); nc(); nc();
        do_redirect(16'h0100);
        ne();
        chk("rw_en_low", 64'(imem_en), 64'(0));
        nc();
        redirect = 1'b0;
        stall    = 1'b0;
        ne();
        chk("rw_flushed", 64'({instr_valid, imem_addr}), 64'({1'b0, 16'h0100}));
        nc(); nc(); nc(); ne();
        chk("rw_first_out", 64'({instr_valid, instr_pc, instr}), 64'({1'b1, 16'h0100, word_at(16'h0100)}));

        // reset while parked in S_WAIT
        do_reset();
        nc(); nc(); nc();
        stall = 1'b1;
        nc(); nc();
        reset = 1'b1;
        ne();
        chk("rs_en_low", 64'(imem_en), 64'(0));
        nc(); ne();
        chk("rs_cleared", 64'({instr_valid, instr_pc, instr, pc, imem_en}), 64'(0));
        stall = 1'b0;

        // randomized stalls and redirects
        do_reset();
        base = consumed;
        for (int c = 0; c < 3000; c++) begin
            redirect = 1'b0;
            stall    = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 49) == 0) begin
                tgt = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                                  : 16'($urandom);
                do_redirect(tgt);
            end
            nc();
        end
        redirect = 1'b0;
        stall    = 1'b0;
        for (int c = 0; c < 8; c++) nc();
        chk("throughput", 64'((consumed - base) >= 300), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
